md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Multiply/divide sequencer for the pipelined CPU's EX stage. Owns the HI/LO registers and a busy counter.
- Models multi-cycle mult/div latency and raises a stall request toward the ID-stage stall logic. The stall logic then freezes PC and IF/ID and flushes ID/EX whenever an MD-type instruction would issue while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX-stage instruction is mult/multu/div/divu and is valid this cycle
- md_op  input  3  EX-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_val  input  32  forwarded rs operand in EX (multiplicand / dividend / mthi-mtlo source)
- rt_val  input  32  forwarded rt operand in EX (multiplier / divisor)
- id_is_md  input  1  ID-stage instruction is any of mult, multu, div, divu, mthi, mtlo, mfhi, mflo
- busy  output  1  operation in progress
- md_stall  output  1  stall request, OR-ed into the existing stall signal
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset, asynchronous and immediate regardless of state: state=IDLE, counter=0, busy=0, hi=0, lo=0, latched result=0. Reset during BUSY abandons the operation; HI/LO stay 0.
- FSM states:
  - IDLE: busy=0.
    - On a clk edge with start=1 and md_op in {1..4}: compute the 64-bit result from rs_val/rt_val, latch it internally, load counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4), go to BUSY.
    - start=1 with md_op outside {1..4}: ignored.
  - BUSY: busy=1.
    - Counter decrements each edge.
    - On the edge where counter==1: write the latched result to hi/lo, counter=0, go to IDLE.
- Latency: start sampled at the edge closing cycle T. busy is high in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES). New hi/lo are visible from cycle T+N+1. HI/LO do not change during BUSY.
- mthi/mtlo (md_op 5/6, start=0) in IDLE: hi<=rs_val or lo<=rs_val on the edge, no busy.
  - In BUSY these writes are ignored. The stall logic guarantees this cannot happen legally.
- start=1 while BUSY: ignored, no restart. A well-formed pipeline never produces this because md_stall prevents it.
- Arithmetic:
  - mult: signed 32x32->64, {hi,lo}=product.
  - multu: unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero (rt_val==0): busy sequence runs normally; hi/lo keep their pre-operation values at completion.
  - Signed overflow case 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- md_stall is combinational: id_is_md & (busy | start). It covers the instruction directly behind a starting mult/div.
- mfhi/mflo read hi/lo outputs directly. The datapath mux is external; stall guarantees it never reads during busy.
- The block has no internal knowledge of pipeline flush. start must be gated valid by the caller.

Test Plan:
- mult: rs=0xFFFFFFFE, rt=0x00000003, start 1 cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy.
- multu with same operands -> after 5 cycles hi=0x00000002, lo=0xFFFFFFFA.
- div: rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 -> lo=3, hi=1.
- Stall: id_is_md=1 in the start cycle and through busy -> md_stall=1 for cycles T..T+10 and 0 in cycle T+11. With id_is_md=0, md_stall=0 throughout.
- mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. mtlo during BUSY -> lo unaffected.
- Divide by zero after mtlo 0xAA/mthi 0x55 -> busy 10 cycles, then hi=0x55, lo=0xAA. Assert reset at busy cycle 3 -> busy=0, hi=lo=0 immediately, no later write.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, models mult/div latency and
// requests an ID-stage stall while an MD instruction would collide with a busy unit.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     res_q, res_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u, calc;
  logic [31:0] a_abs, b_abs, q_mag, r_mag, q_s, r_s;
  logic        is_calc, is_mult, div_zero;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
  assign a_abs = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign b_abs = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign q_mag = a_abs / b_abs;
  assign r_mag = a_abs % b_abs;
  assign q_s   = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = rs_val[31] ? (~r_mag + 32'd1) : r_mag;

  assign div_zero = (rt_val == 32'd0);
  assign is_mult  = (md_op == OpMult) || (md_op == OpMultu);
  assign is_calc  = is_mult || (md_op == OpDiv) || (md_op == OpDivu);

  always_comb begin
    calc = 64'd0;
    unique case (md_op)
      OpMult:  calc = prod_s;
      OpMultu: calc = prod_u;
      OpDiv:   calc = div_zero ? {hi_q, lo_q} : {r_s, q_s};
      OpDivu:  calc = div_zero ? {hi_q, lo_q} : {rt_val == 32'd0 ? 32'd0 : rs_val % rt_val,
                                                  rt_val == 32'd0 ? 32'd0 : rs_val / rt_val};
      default: calc = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && is_calc) begin
          res_d   = calc;
          cnt_d   = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          state_d = StBusy;
        end else if (!start && md_op == OpMthi) begin
          hi_d = rs_val;
        end else if (!start && md_op == OpMtlo) begin
          lo_d = rs_val;
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(1)) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign md_stall = id_is_md & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: table of mult/div vectors with a result scoreboard,
// plus hand sequences for mthi/mtlo, divide by zero and reset during a busy operation.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        id_is_md;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .id_is_md (id_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        id_md;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one start cycle, then follow busy to completion and score the result.
  task automatic run_op(input vec_t v);
    int          n;
    bit          done;
    logic [63:0] e;
    @(posedge clk); #1;
    start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt; id_is_md = v.id_md;
    sb.push_back({v.exp_hi, v.exp_lo});
    #1;
    check("busy_in_start_cycle", busy, 0);
    check("stall_in_start_cycle", md_stall, v.id_md);
    n = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      #1;
      if (busy) begin
        n++;
        check("stall_while_busy", md_stall, v.id_md);
        check("hi_held_while_busy", hi, model_hi);
        check("lo_held_while_busy", lo, model_lo);
      end else begin
        done = 1;
        check("stall_after_busy", md_stall, 0);
        check("busy_cycle_count", n, v.cycles);
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("hi_result", hi, e[63:32]);
          check("lo_result", lo, e[31:0]);
          model_hi = e[63:32];
          model_lo = e[31:0];
        end
      end
    end
    if (!done) check("busy_timeout", 1, 0);
    id_is_md = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'h00000007, 32'h00000002, 1'b0, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{3'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 5};
    vecs[7] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0000000F, 32'h0FFFFFFF, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; id_is_md = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_stall", md_stall, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // mthi in idle: visible next cycle, no busy.
    @(posedge clk); #1;
    md_op = 3'd5; rs_val = 32'h12345678;
    @(posedge clk); #1;
    md_op = 3'd0;
    #1;
    model_hi = 32'h12345678;
    check("mthi_hi", hi, model_hi);
    check("mthi_no_busy", busy, 0);

    // mtlo attempted while busy is dropped; mult 3*4 completes normally.
    v = '{3'd1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 5};
    @(posedge clk); #1;
    start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd6; rs_val = 32'hDEADBEEF;
    @(posedge clk); #1;
    md_op = 3'd0;
    #1;
    check("mtlo_busy_ignored_lo", lo, model_lo);
    check("mtlo_busy_still_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("mtlo_busy_done", busy, 0);
    check("mult_after_mtlo_hi", hi, 32'd0);
    check("mult_after_mtlo_lo", lo, 32'd12);
    model_hi = 32'd0;
    model_lo = 32'd12;

    // Divide by zero keeps the pre-operation HI/LO.
    @(posedge clk); #1;
    md_op = 3'd6; rs_val = 32'hAA;
    @(posedge clk); #1;
    md_op = 3'd5; rs_val = 32'h55;
    @(posedge clk); #1;
    md_op = 3'd0;
    model_hi = 32'h55;
    model_lo = 32'hAA;
    v = '{3'd3, 32'd9, 32'd0, 1'b1, 32'h55, 32'hAA, 10};
    run_op(v);
    v = '{3'd4, 32'd9, 32'd0, 1'b0, 32'h55, 32'hAA, 10};
    run_op(v);

    // Reset in the third busy cycle of a divide clears everything at once.
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_hi", hi, 0);
    check("async_reset_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_hi", hi, 0);
    check("post_reset_lo", lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
